// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared reset constants and reference function for the full adder
package full_adder_pkg;

  localparam logic FA_RST_S  = 1'b0;
  localparam logic FA_RST_CO = 1'b0;

  // Returns {co, s}; X on an input propagates naturally through the gate expressions.
  function automatic logic [1:0] fa_ref(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// rtl/full_adder_if.sv - operand/result bundle for one full adder bit
interface full_adder_if;

  logic a;
  logic b;
  logic c;
  logic s;
  logic co;

  modport master (output a, output b, output c, input s, input co);
  modport slave  (input a, input b, input c, output s, output co);

endinterface

// File: rtl/full_adder_half_adder.sv
// rtl/full_adder_half_adder.sv - half adder leaf used twice inside full_adder
module half_adder (
  input  logic x,
  input  logic y,
  output logic sum,
  output logic carry
);

  assign sum   = x ^ y;
  assign carry = x & y;

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder; FULL_ADDER_REG_OUT_EN adds an output register stage
module full_adder
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co,
  input  logic clk,
  input  logic rst
);

  logic p;
  logic g1;
  logic g2;
  logic s_c;
  logic co_c;

  half_adder u_ha1 (
    .x     (a),
    .y     (b),
    .sum   (p),
    .carry (g1)
  );

  half_adder u_ha2 (
    .x     (p),
    .y     (c),
    .sum   (s_c),
    .carry (g2)
  );

  assign co_c = g1 | g2;

`ifdef FULL_ADDER_REG_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s  <= FA_RST_S;
      co <= FA_RST_CO;
    end else begin
      s  <= s_c;
      co <= co_c;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign s  = s_c;
  assign co = co_c;
`endif

`ifndef SYNTHESIS
  always_comb begin
    if (!$isunknown({a, b, c})) begin
      assert ({co_c, s_c} == fa_ref(a, b, c));
    end
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed self-checking bench for full_adder (both build options)
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  full_adder_if fa_if ();

  full_adder dut (
    .a   (fa_if.a),
    .b   (fa_if.b),
    .c   (fa_if.c),
    .s   (fa_if.s),
    .co  (fa_if.co),
    .clk (clk),
    .rst (rst)
  );

  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rs;
  logic       cin;
  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_chain
    full_adder u_bit (
      .a   (ra[i]),
      .b   (rb[i]),
      .c   (carry[i]),
      .s   (rs[i]),
      .co  (carry[i+1]),
      .clk (clk),
      .rst (rst)
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] abc);
    fa_if.a = abc[2];
    fa_if.b = abc[1];
    fa_if.c = abc[0];
  endtask

  // Vectors {a,b,c} and hand-written expected {co,s}.
  logic [2:0] vec_in  [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b101, 3'b111};
  logic [1:0] vec_exp [8] = '{2'b00,  2'b01,  2'b01,  2'b01,  2'b10,  2'b10,  2'b10,  2'b11};

  initial begin
    drive(3'b000);
    ra  = 4'b0000;
    rb  = 4'b0000;
    cin = 1'b0;

`ifdef FULL_ADDER_REG_OUT_EN
    #2;
    check("reset_state", {3'b0, fa_if.co, fa_if.s}, 5'b00000);
    @(posedge clk); #1;
    check("reset_held", {3'b0, fa_if.co, fa_if.s}, 5'b00000);
    @(negedge clk);
    rst = 1'b0;

    foreach (vec_in[i]) begin
      @(negedge clk);
      drive(vec_in[i]);
      @(posedge clk); #1;
      check($sformatf("reg_sweep_%b", vec_in[i]), {3'b0, fa_if.co, fa_if.s}, {3'b0, vec_exp[i]});
    end

    @(negedge clk);
    drive(3'b000);
    @(posedge clk); #1;
    @(negedge clk);
    drive(3'b101);
    #2;
    check("latency_before_edge", {3'b0, fa_if.co, fa_if.s}, 5'b00000);
    @(posedge clk); #1;
    check("latency_after_edge", {3'b0, fa_if.co, fa_if.s}, 5'b00010);
    @(negedge clk);
    drive(3'b000);
    #3;
    check("latency_hold", {3'b0, fa_if.co, fa_if.s}, 5'b00010);

    @(negedge clk);
    drive(3'b111);
    @(posedge clk); #1;
    check("pre_reset_111", {3'b0, fa_if.co, fa_if.s}, 5'b00011);
    #1 rst = 1'b1;
    #1;
    check("async_reset_now", {3'b0, fa_if.co, fa_if.s}, 5'b00000);
    @(posedge clk); #1;
    check("async_reset_hold", {3'b0, fa_if.co, fa_if.s}, 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release_111", {3'b0, fa_if.co, fa_if.s}, 5'b00011);

    @(negedge clk);
    drive(3'b000);
    @(posedge clk); #1;
    check("glitch_base", {3'b0, fa_if.co, fa_if.s}, 5'b00000);
    #1 fa_if.a = 1'b1;
    #1;
    check("glitch_mid", {3'b0, fa_if.co, fa_if.s}, 5'b00000);
    #1 fa_if.a = 1'b0;
    @(posedge clk); #1;
    check("glitch_after_edge", {3'b0, fa_if.co, fa_if.s}, 5'b00000);

    ra = 4'b1011;
    rb = 4'b0110;
    cin = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ripple_1011_0110", {carry[4], rs}, 5'b10001);
`else
    foreach (vec_in[i]) begin
      drive(vec_in[i]);
      #5;
      check($sformatf("sweep_%b", vec_in[i]), {3'b0, fa_if.co, fa_if.s}, {3'b0, vec_exp[i]});
    end

    rst = 1'b1;
    drive(3'b110);
    #5;
    check("ignores_rst", {3'b0, fa_if.co, fa_if.s}, 5'b00010);
    rst = 1'b0;

    ra = 4'b1011;
    rb = 4'b0110;
    cin = 1'b0;
    #5;
    check("ripple_1011_0110", {carry[4], rs}, 5'b10001);
    ra = 4'b1111;
    rb = 4'b0000;
    cin = 1'b1;
    #5;
    check("ripple_full_carry", {carry[4], rs}, 5'b10000);

    fa_if.a = 1'bx;
    fa_if.b = 1'b0;
    fa_if.c = 1'b0;
    #5;
    check("xprop_s", {4'b0, fa_if.s}, {4'b0, fa_ref(fa_if.a, fa_if.b, fa_if.c) >> 0 & 2'b01});
    check("xprop_co_zero", {4'b0, fa_if.co}, 5'b00000);
    fa_if.a = 1'b1;
    fa_if.b = 1'b1;
    fa_if.c = 1'bx;
    #5;
    check("xprop_co_one", {4'b0, fa_if.co}, 5'b00001);
    check("xprop_s2", {4'b0, fa_if.s}, {4'b0, fa_ref(fa_if.a, fa_if.b, fa_if.c) & 2'b01});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
